instr_fetch_ctrl: RTL and testbench

Fetch and load sequencer for the single-cycle processor's 32-entry × 32-bit instruction memory. Owns the memory address port and shares it between two users: a boot-time program loader that streams words into memory, and the fetch path that drives the program counter and registers the fetched instruction for the decoder. It also handles stalls, branch/jump redirects and an optional halt-opcode stop.

---
 rtl/instr_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory load/fetch sequencer; optional halt-opcode stop under FETCH_HALT_DETECT_EN.
// Latency: fetched word registered into instr 1 cycle after pc presents it; load writes are combinational.
// Backpressure: load_ready is high for all of LOAD; stall freezes fetch; redirect inserts one bubble.
module instr_fetch_ctrl #(
    parameter int          ADDR_W  = 5,
    parameter int          DATA_W  = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] lcnt, lcnt_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              instr_valid_nxt;
    logic              is_halt_op;

    // With detection disabled the comparison folds to constant 0.
    assign is_halt_op = HALT_EN && (imem_rdata[DATA_W-1 -: 6] == HALT_OP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            lcnt        <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            lcnt        <= lcnt_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        lcnt_nxt        = lcnt;
        instr_nxt       = instr;
        instr_valid_nxt = instr_valid;
        load_ready      = 1'b0;
        imem_we         = 1'b0;
        imem_wdata      = '0;
        imem_addr       = '0;
        halted          = 1'b0;

        case (state)
            IDLE, HALT: begin
                halted          = (state == HALT);
                instr_valid_nxt = 1'b0;
                if (load_req) begin
                    state_nxt = LOAD;
                    lcnt_nxt  = '0;
                end else if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                imem_addr  = lcnt;
                imem_wdata = load_data;
                imem_we    = load_valid;
                if (load_valid) begin
                    if (load_last || (lcnt == LAST_ADDR)) begin
                        state_nxt = IDLE;
                    end
                    // Saturate at the top word so the counter never wraps.
                    if (lcnt != LAST_ADDR) begin
                        lcnt_nxt = lcnt + 1'b1;
                    end
                end
            end
            RUN: begin
                imem_addr = pc;
                if (redirect) begin
                    pc_nxt          = redirect_addr;
                    instr_valid_nxt = 1'b0;
                end else if (!stall) begin
                    instr_nxt       = imem_rdata;
                    instr_valid_nxt = 1'b1;
                    if (is_halt_op) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl with an in-bench behavioural model and memory.
module tb_instr_fetch_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic          start = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic [AW-1:0] redirect_addr = '0;
    logic          load_ready, imem_we, instr_valid, halted;
    logic [AW-1:0] imem_addr, pc;
    logic [DW-1:0] imem_wdata, imem_rdata, instr;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;

    logic [DW-1:0] mem  [N];
    logic [DW-1:0] mmem [N];
    logic [DW-1:0] full [N];
    logic [DW-1:0] part [10];
    logic [DW-1:0] w4   [4];

    int            m_mode, m_pc, m_lcnt;
    logic [DW-1:0] m_instr;
    logic          m_vld;

    instr_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .load_req(load_req), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .start(start), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h1000_0000 + DW'(i) * 32'h0000_0101;
    endfunction

    assign imem_rdata = mem[imem_addr];

    // Environment memory: inputs only change just after a rising edge, so the
    // write strobe seen at the falling edge is the one the next rising edge sees.
    initial begin
        for (int i = 0; i < N; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (imem_we) begin
                mem[imem_addr] = imem_wdata;
                we_cnt++;
            end
        end
    end

    // Behavioural reference model.
    initial begin
        for (int i = 0; i < N; i++) mmem[i] = init_word(i);
        m_mode = M_IDLE; m_pc = 0; m_lcnt = 0; m_instr = '0; m_vld = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_mode = M_IDLE; m_pc = 0; m_lcnt = 0; m_instr = '0; m_vld = 1'b0;
            end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
                m_vld = 1'b0;
                if (load_req) begin
                    m_mode = M_LOAD; m_lcnt = 0;
                end else if (start) begin
                    m_mode = M_RUN; m_pc = 0;
                end
            end else if (m_mode == M_LOAD) begin
                if (load_valid) begin
                    mmem[m_lcnt] = load_data;
                    if (load_last || m_lcnt == N - 1) m_mode = M_IDLE;
                    m_lcnt = (m_lcnt < N - 1) ? m_lcnt + 1 : N - 1;
                end
            end else begin
                if (redirect) begin
                    m_pc = int'(redirect_addr); m_vld = 1'b0;
                end else if (!stall) begin
                    m_instr = mmem[m_pc];
                    m_vld   = 1'b1;
                    if (HALT_EN && m_instr[31:26] == 6'h3F) m_mode = M_HALT;
                    else m_pc = (m_pc + 1) % N;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int e_addr;
        e_addr = (m_mode == M_LOAD) ? m_lcnt : (m_mode == M_RUN) ? m_pc : 0;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr", instr, m_instr);
        chk("instr_valid", 32'(instr_valid), 32'(m_vld));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
        chk("imem_we", 32'(imem_we), 32'(m_mode == M_LOAD && load_valid));
        chk("imem_addr", 32'(imem_addr), 32'(e_addr));
        if (m_mode == M_LOAD && load_valid) chk("imem_wdata", imem_wdata, load_data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int guard;
        w4[0] = 32'h0001_1850; w4[1] = 32'h1; w4[2] = 32'h2; w4[3] = 32'hFC00_0000;
        for (int i = 0; i < N; i++) begin
            full[i] = $urandom;
            if (full[i][31:26] == 6'h3F) full[i][31] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_instr", instr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ready", 32'(load_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        reset = 1'b1;

        // Four-word load with load_last
        we_cnt = 0;
        load_req = 1'b1; cyc(); load_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = w4[i]; load_last = (i == 3);
            cyc();
        end
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        chk("load4_we_cycles", 32'(we_cnt), 4);
        chk("load4_mem0", mem[0], 32'h0001_1850);
        chk("load4_mem3", mem[3], 32'hFC00_0000);
        chk("load4_back_idle", 32'(load_ready), 0);

        // Run the loaded program
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); chk("run_i0", instr, 32'h0001_1850); chk("run_v0", 32'(instr_valid), 1);
        cyc(); chk("run_i1", instr, 32'h1);
        cyc(); chk("run_i2", instr, 32'h2);
        cyc(); chk("run_i3", instr, 32'hFC00_0000);
        chk("run_halted", 32'(halted), 32'(HALT_EN));
        chk("run_pc", 32'(pc), HALT_EN ? 32'd3 : 32'd4);
        cyc();
        if (HALT_EN) chk("halt_bubble", 32'(instr_valid), 0);

        // Reset mid-run, then fill all 32 words with no load_last
        reset = 1'b0; #1;
        chk("rstrun_pc", 32'(pc), 0);
        cyc(); reset = 1'b1;
        load_req = 1'b1; cyc(); load_req = 1'b0;
        k = 0; guard = 0;
        while (m_mode == M_LOAD && guard < 200) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = full[k];
            cyc();
            if (load_valid) k++;
            guard++;
        end
        load_valid = 1'b0;
        chk("full_load_words", 32'(k), 32);
        chk("full_load_exit", 32'(load_ready), 0);
        chk("full_mem31", mem[31], full[31]);

        // Stall at pc=5, redirect to 20 under stall, then wrap
        start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        chk("pre_stall_pc", 32'(pc), 5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", 32'(pc), 5);
            chk("stall_instr", instr, full[4]);
        end
        redirect = 1'b1; redirect_addr = 5'd20;
        cyc();
        chk("redir_bubble", 32'(instr_valid), 0);
        chk("redir_pc", 32'(pc), 20);
        redirect = 1'b0; stall = 1'b0;
        cyc();
        chk("redir_target", instr, full[20]);
        chk("redir_valid", 32'(instr_valid), 1);
        repeat (11) cyc();
        chk("wrap_pc", 32'(pc), 0);
        chk("wrap_instr", instr, full[31]);

        // Random stall/redirect traffic
        repeat (300) begin
            stall         = ($urandom_range(0, 4) == 0);
            redirect      = ($urandom_range(0, 9) == 0);
            redirect_addr = AW'($urandom);
            cyc();
        end
        stall = 1'b0; redirect = 1'b0;

        // load_req and start together
        reset = 1'b0; cyc(); reset = 1'b1;
        load_req = 1'b1; start = 1'b1; cyc(); load_req = 1'b0; start = 1'b0;
        chk("both_load", 32'(load_ready), 1);

        // Reset mid-LOAD at lcnt=10 with load_valid high
        for (int i = 0; i < 10; i++) begin
            part[i] = $urandom;
            load_valid = 1'b1; load_data = part[i];
            cyc();
        end
        chk("lcnt10_addr", 32'(imem_addr), 10);
        #2 reset = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 0);
        chk("arst_ready", 32'(load_ready), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_valid", 32'(instr_valid), 0);
        cyc();
        load_valid = 1'b0;
        reset = 1'b1;
        chk("arst_mem_kept", mem[9], part[9]);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
